// File: rtl/dds_wave_gen.sv
// dds_wave_gen: direct digital synthesis core. A phase accumulator advances once per
// Fg_clk period (every second pll_clk) and drives a 3-stage pipeline that shapes
// saw/triangle/square/ramp-down samples, scales them by amplitude and feeds the DAC.
// Optional feature macro: DDS_DITHER_EN adds a 16-bit LFSR offset to the phase
// just below the 12-bit phase field.
module dds_wave_gen #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned DAC_W = 10
) (
    input  logic             pll_clk,
    input  logic             Resetn,
    input  logic             run,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [ACC_W-1:0] cfg_ftw,
    input  logic [1:0]       cfg_wave,
    input  logic [7:0]       cfg_amp,
    input  logic [7:0]       cfg_duty,
    output logic [DAC_W-1:0] dac_data,
    output logic             dac_valid,
    output logic             wrap
);

    localparam logic [DAC_W-1:0] MidScale = {1'b1, {(DAC_W-1){1'b0}}};

    logic tick;
    logic ph_q;

    assign tick = ~ph_q;

    // Phase bit mirroring Fg_clk; datapath registers only move on tick edges
    always_ff @(posedge pll_clk or negedge Resetn) begin
        if (!Resetn) begin
            ph_q <= 1'b0;
        end else begin
            ph_q <= ~ph_q;
        end
    end

    logic [ACC_W-1:0] sh_ftw_q, ftw_q;
    logic [1:0]       sh_wave_q, wave_q;
    logic [7:0]       sh_amp_q, amp_q;
    logic [7:0]       sh_duty_q, duty_q;
    logic             rdy_q;

    // Config handshake: accept into shadow, copy the whole set to active on next tick
    always_ff @(posedge pll_clk or negedge Resetn) begin
        if (!Resetn) begin
            sh_ftw_q  <= '0;
            sh_wave_q <= 2'd0;
            sh_amp_q  <= 8'd0;
            sh_duty_q <= 8'd128;
            ftw_q     <= '0;
            wave_q    <= 2'd0;
            amp_q     <= 8'd0;
            duty_q    <= 8'd128;
            rdy_q     <= 1'b1;
        end else if (cfg_valid && rdy_q) begin
            sh_ftw_q  <= cfg_ftw;
            sh_wave_q <= cfg_wave;
            sh_amp_q  <= cfg_amp;
            sh_duty_q <= cfg_duty;
            rdy_q     <= 1'b0;
        end else if (tick && !rdy_q) begin
            ftw_q     <= sh_ftw_q;
            wave_q    <= sh_wave_q;
            amp_q     <= sh_amp_q;
            duty_q    <= sh_duty_q;
            rdy_q     <= 1'b1;
        end
    end

    assign cfg_ready = rdy_q;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   acc_sum;
    logic             wrap_q;

    assign acc_sum = {1'b0, acc_q} + {1'b0, ftw_q};

    // Stage 1: phase accumulator; wrap is a single-cycle pulse on carry-out
    always_ff @(posedge pll_clk or negedge Resetn) begin
        if (!Resetn) begin
            acc_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            if (tick) begin
                acc_q <= run ? acc_sum[ACC_W-1:0] : '0;
            end
            wrap_q <= tick & run & acc_sum[ACC_W];
        end
    end

    assign wrap = wrap_q;

    logic [11:0] p;

`ifdef DDS_DITHER_EN
    logic [15:0]      lfsr_q;
    logic             lfsr_fb;
    logic [ACC_W-1:0] acc_dith;
    logic             unused_dith;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Dither LFSR (taps 16,14,13,11) stepping once per tick while running
    always_ff @(posedge pll_clk or negedge Resetn) begin
        if (!Resetn) begin
            lfsr_q <= 16'hACE1;
        end else if (tick && run) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    assign acc_dith    = acc_q + ({{(ACC_W-4){1'b0}}, lfsr_q[3:0]} << (ACC_W-16));
    assign p           = acc_dith[ACC_W-1 -: 12];
    assign unused_dith = ^acc_dith[ACC_W-13:0];
`else
    assign p = acc_q[ACC_W-1 -: 12];
`endif

    logic [11:0] raw;

    // Waveform shaping from the 12-bit phase
    always_comb begin
        raw = p;
        case (wave_q)
            2'd0:    raw = p;
            2'd1:    raw = p[11] ? {~p[10:0], 1'b0} : {p[10:0], 1'b0};
            2'd2:    raw = (p[11:4] < duty_q) ? 12'hFFF : 12'h000;
            default: raw = ~p;
        endcase
    end

    logic [11:0] r_q;
    logic [7:0]  amp2_q;
    logic        vr_q;

    // Stage 2: register raw sample; amplitude travels with it so a config
    // change never mixes old shape with new scale
    always_ff @(posedge pll_clk or negedge Resetn) begin
        if (!Resetn) begin
            r_q    <= 12'd0;
            amp2_q <= 8'd0;
            vr_q   <= 1'b0;
        end else if (tick) begin
            vr_q <= run;
            if (run) begin
                r_q    <= raw;
                amp2_q <= amp_q;
            end
        end
    end

    logic signed [12:0] s_val;
    logic signed [20:0] prod;
    logic [11:0]        o_val;
    logic               unused_bits;

    assign s_val = $signed({1'b0, r_q}) - 13'sd2048;
    assign prod  = 21'(s_val) * 21'($signed({1'b0, amp2_q}));
    // prod[20:8] is the floor-shifted value; adding midscale mod 4096 stays in range
    assign o_val = prod[19:8] + 12'h800;
    assign unused_bits = ^{prod[20], prod[7:0], o_val};

    logic [DAC_W-1:0] dac_q;
    logic             dac_valid_q;

    // Stage 3: scaled output; midscale whenever the pipeline is not full
    always_ff @(posedge pll_clk or negedge Resetn) begin
        if (!Resetn) begin
            dac_q       <= MidScale;
            dac_valid_q <= 1'b0;
        end else if (tick) begin
            if (run && vr_q) begin
                dac_q       <= o_val[11 -: DAC_W];
                dac_valid_q <= 1'b1;
            end else begin
                dac_q       <= MidScale;
                dac_valid_q <= 1'b0;
            end
        end
    end

    assign dac_data  = dac_q;
    assign dac_valid = dac_valid_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen: a per-tick behavioural model pushes expected
// samples; a monitor pops and compares whenever the DUT presents a valid sample.
module tb_dds_wave_gen;

    localparam int ACC_W = 32;
    localparam int DAC_W = 10;
    localparam int MID   = 1 << (DAC_W - 1);

    logic             pll_clk;
    logic             Resetn;
    logic             run;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [ACC_W-1:0] cfg_ftw;
    logic [1:0]       cfg_wave;
    logic [7:0]       cfg_amp;
    logic [7:0]       cfg_duty;
    logic [DAC_W-1:0] dac_data;
    logic             dac_valid;
    logic             wrap;

    dds_wave_gen #(
        .ACC_W(ACC_W),
        .DAC_W(DAC_W)
    ) dut (
        .pll_clk  (pll_clk),
        .Resetn   (Resetn),
        .run      (run),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ftw  (cfg_ftw),
        .cfg_wave (cfg_wave),
        .cfg_amp  (cfg_amp),
        .cfg_duty (cfg_duty),
        .dac_data (dac_data),
        .dac_valid(dac_valid),
        .wrap     (wrap)
    );

    initial pll_clk = 1'b0;
    always #5 pll_clk = ~pll_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sample value from the waveform definitions, using plain integer/real arithmetic
    function automatic int ref_sample(input longint unsigned acc, input int wave,
                                      input int amp, input int duty);
        int  p, r, s, o;
        real y;
        p = int'((acc >> (ACC_W - 12)) & 64'hFFF);
        case (wave)
            0:       r = p;
            1:       r = (p < 2048) ? 2 * p : 2 * (4095 - p);
            2:       r = ((p / 16) < duty) ? 4095 : 0;
            default: r = 4095 - p;
        endcase
        s = r - 2048;
        y = $floor(real'(s * amp) / 256.0);
        o = int'(y) + 2048;
        return o / (1 << (12 - DAC_W));
    endfunction

    // Reference model state
    bit              m_ph = 0;
    bit              m_tick = 0;
    longint unsigned m_acc = 0;
    int              a_ftw = 0, a_wave = 0, a_amp = 0, a_duty = 128;
    int              s_ftw = 0, s_wave = 0, s_amp = 0, s_duty = 128;
    bit              m_ready = 1, m_prev_run = 0, exp_valid = 0, exp_wrap = 0;
    int              exp_q[$];

    always @(posedge pll_clk or negedge Resetn) begin
        if (!Resetn) begin
            m_ph = 0; m_tick = 0; m_acc = 0;
            a_ftw = 0; a_wave = 0; a_amp = 0; a_duty = 128;
            m_ready = 1; m_prev_run = 0; exp_valid = 0; exp_wrap = 0;
            exp_q.delete();
        end else begin
            m_tick   = (m_ph == 0);
            exp_wrap = 0;
            if (m_tick) begin
                if (run) begin
                    exp_q.push_back(ref_sample(m_acc, a_wave, a_amp, a_duty));
                    m_acc = m_acc + longint'(unsigned'(a_ftw));
                    if (m_acc >= (64'd1 << ACC_W)) begin
                        exp_wrap = 1;
                        m_acc    = m_acc - (64'd1 << ACC_W);
                    end
                    exp_valid = m_prev_run;
                end else begin
                    m_acc     = 0;
                    exp_valid = 0;
                    exp_q.delete();
                end
                m_prev_run = run;
            end
            if (cfg_valid && m_ready) begin
                s_ftw = int'(cfg_ftw); s_wave = cfg_wave; s_amp = cfg_amp; s_duty = cfg_duty;
                m_ready = 0;
            end else if (m_tick && !m_ready) begin
                a_ftw = s_ftw; a_wave = s_wave; a_amp = s_amp; a_duty = s_duty;
                m_ready = 1;
            end
            m_ph = ~m_ph;
        end
    end

    // Monitor: compare every cycle, pop scoreboard on each new valid sample
    int wrap_cnt = 0;
    int last_exp = MID;

    always @(posedge pll_clk) begin
        #1;
        if (!Resetn) begin
            last_exp = MID;
        end else begin
            check("cfg_ready", cfg_ready, m_ready);
            check("wrap", wrap, exp_wrap);
            check("dac_valid", dac_valid, exp_valid);
            if (wrap) wrap_cnt++;
            if (m_tick) begin
                if (dac_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_empty: got sample %0d, expected none", dac_data);
                    end else begin
                        last_exp = exp_q.pop_front();
                        check("dac_data", dac_data, last_exp);
                    end
                end else begin
                    last_exp = MID;
                    check("dac_mid", dac_data, MID);
                end
            end else begin
                check("dac_hold", dac_data, last_exp);
            end
        end
    end

    // Caller is at a negedge; valid is held until accepted
    task automatic cfg_write(input logic [31:0] ftw, input logic [1:0] wave,
                             input logic [7:0] amp, input logic [7:0] duty);
        int n;
        bit done;
        n = 0;
        done = 0;
        cfg_ftw = ftw; cfg_wave = wave; cfg_amp = amp; cfg_duty = duty;
        cfg_valid = 1'b1;
        while (!done) begin
            done = cfg_ready;
            @(negedge pll_clk);
            n++;
            if (!done && n > 8) begin
                checks++;
                errors++;
                $display("FAIL cfg_accept_timeout: got ready 0, expected 1");
                done = 1;
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int exp);
        int n;
        n = 0;
        while (!dac_valid && n < 10) begin
            @(negedge pll_clk);
            n++;
        end
        check({name, "_valid"}, dac_valid, 1);
        check(name, dac_data, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, hi, lo;
        Resetn = 1'b0; run = 1'b0; cfg_valid = 1'b0;
        cfg_ftw = '0; cfg_wave = 2'd0; cfg_amp = 8'd0; cfg_duty = 8'd0;
        repeat (3) @(negedge pll_clk);
        check("rst_dac_data", dac_data, MID);
        check("rst_dac_valid", dac_valid, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_wrap", wrap, 0);
        Resetn = 1'b1;
        @(negedge pll_clk);

        // Sawtooth from acc 0: first sample 2, one wrap per 256 ticks
        cfg_write(32'h0100_0000, 2'd0, 8'd255, 8'd128);
        repeat (2) @(negedge pll_clk);
        run = 1'b1;
        wait_valid("first_saw", 2);
        w0 = wrap_cnt;
        repeat (512) @(negedge pll_clk);
        check("wrap_count", wrap_cnt - w0, 1);

        // Square: half the tick windows at 1021, half at 2
        cfg_write(32'h1000_0000, 2'd2, 8'd255, 8'd128);
        repeat (6) @(negedge pll_clk);
        hi = 0;
        for (int i = 0; i < 64; i++) begin
            if (dac_data == 10'd1021) hi++;
            @(negedge pll_clk);
        end
        check("square_high_cycles", hi, 32);

        // Zero amplitude stays at midscale while valid
        cfg_write($urandom(), 2'($urandom_range(0, 3)), 8'd0, 8'($urandom_range(0, 255)));
        repeat (8) @(negedge pll_clk);
        check("amp0_valid", dac_valid, 1);
        check("amp0_data", dac_data, MID);

        // Mid-run retune and reshape in one transfer
        cfg_write(32'h0100_0000, 2'd0, 8'd255, 8'd128);
        repeat (10) @(negedge pll_clk);
        for (int k = 0; k < 2; k++) begin
            if (k == 1) @(negedge pll_clk);
            cfg_write(32'h0200_0000, 2'd1, 8'd255, 8'd128);
            lo = 0;
            while (!cfg_ready && lo < 5) begin
                lo++;
                @(negedge pll_clk);
            end
            check("ready_low_in_range", int'(lo >= 1 && lo <= 2), 1);
            repeat (20) @(negedge pll_clk);
            cfg_write(32'h0100_0000, 2'd0, 8'd255, 8'd128);
            repeat (4) @(negedge pll_clk);
        end

        // Randomized configs, run gating and handshake alignment
        for (int it = 0; it < 25; it++) begin
            run = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 1) == 1) @(negedge pll_clk);
            cfg_write($urandom(), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)));
            repeat ($urandom_range(4, 40)) @(negedge pll_clk);
        end

        // Asynchronous reset mid-run
        run = 1'b1;
        cfg_write(32'h0300_0000, 2'd3, 8'd200, 8'd64);
        repeat (20) @(negedge pll_clk);
        #2 Resetn = 1'b0;
        #1;
        check("arst_dac_data", dac_data, MID);
        check("arst_dac_valid", dac_valid, 0);
        check("arst_cfg_ready", cfg_ready, 1);
        check("arst_wrap", wrap, 0);
        @(negedge pll_clk);
        run = 1'b0;
        @(negedge pll_clk);
        Resetn = 1'b1;
        @(negedge pll_clk);
        cfg_write(32'h0100_0000, 2'd0, 8'd255, 8'd128);
        repeat (3) @(negedge pll_clk);
        run = 1'b1;
        wait_valid("restart_first", 2);
        repeat (40) @(negedge pll_clk);
        run = 1'b0;
        repeat (6) @(negedge pll_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_wave_gen.md
# dds_wave_gen

Direct digital synthesis waveform core for the function generator. It runs on pll_clk and advances one sample per Fg_clk period (every second pll_clk cycle) using an internal phase that tracks the divided clock. Each sample is a sawtooth, triangle, square or ramp-down value scaled by amplitude. It drives the DAC data bus so each sample is stable across the following Dac_clk rising edge.

## Interface
- ACC_W, 32, phase accumulator width (>= 16)
- DAC_W, 10, DAC data width (<= 12)

- pll_clk  in  1  system clock; Fg_clk and Dac_clk are derived from it
- Resetn  in  1  reset, asynchronous, active-low
- run  in  1  1 = generate; 0 = accumulator cleared, output midscale
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept; transfer when valid && ready
- cfg_ftw  in  ACC_W  frequency tuning word
- cfg_wave  in  2  0 saw, 1 triangle, 2 square, 3 ramp-down
- cfg_amp  in  8  amplitude, 0..255 (255 ≈ full scale)
- cfg_duty  in  8  square duty threshold
- dac_data  out  DAC_W  sample to DAC
- dac_valid  out  1  dac_data is a live sample
- wrap  out  1  one-pll_clk pulse on accumulator carry-out

## Operation
- Phase bit ph: reset 0, toggles every pll_clk; mirrors Fg_clk. tick = (ph == 0). All datapath registers advance only on tick edges.
- Config: an accepted transfer loads a shadow register and drops cfg_ready. At the next tick the shadow (ftw, wave, amp, duty) is copied atomically to the active set and cfg_ready returns high. A partial update never occurs. Active reset values: ftw 0, wave 0, amp 0, duty 128.
- Stage 1 (tick): if run, acc <= acc + ftw and wrap pulses on carry-out; else acc <= 0.
- p = top 12 bits of acc (see Configuration).
- Stage 2 (tick): raw r, 12 bits unsigned:
  - saw: r = p
  - triangle: r = {p[11] ? ~p[10:0] : p[10:0], 0}
  - square: r = (p[11:4] < duty) ? 4095 : 0
  - ramp-down: r = ~p
- Stage 3 (tick): s = r − 2048 (signed); y = (s × amp) >>> 8, arithmetic; o = y + 2048. dac_data = o[11 -: DAC_W], truncated.
- dac_valid is set at the second tick after run rises, when the pipeline is full. It clears at the first tick with run = 0, and dac_data is then forced to midscale (2^(DAC_W−1)).
- run = 0 clears acc and the pipeline valid flags. Config handshake stays operational.

## Timing
- Reset values: dac_data = midscale (512 for DAC_W = 10), dac_valid 0, wrap 0, cfg_ready 1, acc 0, ph 0. Deassertion of Resetn is synchronous to pll_clk.
- Latency: the acc value written at tick n appears on dac_data at tick n+2.
- dac_data changes only on tick edges. It is stable for 2 pll_clk cycles and straddles the Dac_clk rise on the intermediate pll_clk negedge.
- cfg_ready is low for 1–2 pll_clk cycles after an accept. If cfg_valid arrives on a tick edge, it is accepted and applied at the following tick.
- Resetn asserted mid-run forces all outputs to reset values immediately.

## Configuration
- DDS_DITHER_EN defined:
  - 16-bit Fibonacci LFSR, taps 16, 14, 13, 11, seed 0xACE1, advances on each tick while run = 1.
  - p = top 12 bits of (acc + (lfsr[3:0] << (ACC_W − 16))).
- DDS_DITHER_EN undefined: no LFSR logic; p = acc[ACC_W−1 -: 12].

## Test plan
All scenarios use defaults and have DDS_DITHER_EN undefined.
- Reset: Resetn low → dac_data 512, dac_valid 0, cfg_ready 1, wrap 0.
- Saw, ftw 0x01000000, amp 255, run 1 → first valid dac_data 2; p steps 16 per tick; wrap once every 256 ticks (512 pll_clk).
- Square, ftw 0x10000000, duty 128, amp 255 → alternates 8 ticks at 1021 and 8 ticks at 2; dac_data is constant within each 2-cycle tick window.
- amp 0, any wave, run 1 → dac_data 512 with dac_valid 1.
- Mid-run config (ftw 0x01000000 → 0x02000000, wave saw → triangle) → both take effect on the same tick; cfg_ready low ≤ 2 cycles; no mixed sample.
- Resetn pulsed low mid-run → outputs are at reset values within the same cycle; after release, run restarts from acc 0.
